// File: rtl/act_pkg.sv
// Shared types for the streaming activation unit: activation modes and the
// per-beat configuration captured alongside each input vector.
package act_pkg;

  localparam int ACT_DATA_WIDTH = 16;
  localparam int ACT_SHIFT_W    = 4;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'b00,
    ACT_LEAKY  = 2'b01,
    ACT_CLIP   = 2'b10,
    ACT_BYPASS = 2'b11
  } act_mode_e;

  typedef struct packed {
    act_mode_e                          mode;
    logic [ACT_SHIFT_W-1:0]             leak_shift;
    logic signed [ACT_DATA_WIDTH-1:0]   clip_max;
  } act_cfg_t;

endpackage

// File: rtl/act_lane.sv
// One combinational activation lane; also flags negative inputs and
// CLIP-mode inputs above the ceiling for the optional statistics counters.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = ACT_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_cfg_t                     cfg,
  output logic signed [DATA_WIDTH-1:0] y,
  output logic                         is_neg,
  output logic                         is_clip
);

  localparam logic signed [DATA_WIDTH-1:0] ZERO = '0;

  logic signed [DATA_WIDTH-1:0] cmax;

  assign cmax    = cfg.clip_max;
  assign is_neg  = (x < ZERO);
  assign is_clip = (cfg.mode == ACT_CLIP) && (x > cmax);

  // A non-positive ceiling forces CLIP results to zero rather than passing it through.
  always_comb begin
    y = x;
    case (cfg.mode)
      ACT_RELU:  y = (x > ZERO) ? x : ZERO;
      ACT_LEAKY: y = (x >= ZERO) ? x : (x >>> cfg.leak_shift);
      ACT_CLIP: begin
        if ((x <= ZERO) || (cmax <= ZERO)) y = ZERO;
        else if (x > cmax)                 y = cmax;
        else                               y = x;
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/act_stream.sv
// Two-stage stallable activation pipeline with valid/ready handshakes.
// Define ACT_STATS_EN to add the saturating neg_cnt/clip_cnt statistics.
module act_stream
  import act_pkg::*;
#(
  parameter int VEC_SIZE   = 4,
  parameter int DATA_WIDTH = ACT_DATA_WIDTH,
  parameter int FIXED_PNT  = 8,
  parameter int SHIFT_W    = ACT_SHIFT_W,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_vec [VEC_SIZE],
  input  act_mode_e                    mode,
  input  logic [SHIFT_W-1:0]           leak_shift,
  input  logic signed [DATA_WIDTH-1:0] clip_max,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_vec [VEC_SIZE]
`ifdef ACT_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [CNT_WIDTH-1:0]         neg_cnt,
  output logic [CNT_WIDTH-1:0]         clip_cnt
`endif
);

  // The config struct has fixed package widths, so reject mismatched overrides.
  if (DATA_WIDTH != ACT_DATA_WIDTH || SHIFT_W != ACT_SHIFT_W ||
      FIXED_PNT >= DATA_WIDTH || CNT_WIDTH < 1) begin : g_bad_cfg
    $error("act_stream: unsupported parameter combination");
  end

  logic                         s1_valid, s2_valid, adv1, adv2;
  logic signed [DATA_WIDTH-1:0] s1_vec [VEC_SIZE];
  act_cfg_t                     s1_cfg;
  logic signed [DATA_WIDTH-1:0] lane_y [VEC_SIZE];
  logic [VEC_SIZE-1:0]          lane_neg, lane_clip;
  logic signed [DATA_WIDTH-1:0] s2_vec [VEC_SIZE];

  assign adv2      = s1_valid & (~s2_valid | out_ready);
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign out_vec   = s2_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cfg   <= '0;
      for (int i = 0; i < VEC_SIZE; i++) s1_vec[i] <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_vec <= in_vec;
        s1_cfg <= '{mode: mode, leak_shift: leak_shift, clip_max: clip_max};
      end
    end
  end

  for (genvar g = 0; g < VEC_SIZE; g++) begin : g_lane
    act_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .x       (s1_vec[g]),
      .cfg     (s1_cfg),
      .y       (lane_y[g]),
      .is_neg  (lane_neg[g]),
      .is_clip (lane_clip[g])
    );
  end

  // S2 drains on an output transfer even when S1 has nothing to hand over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      for (int i = 0; i < VEC_SIZE; i++) s2_vec[i] <= '0;
    end else if (adv2) begin
      s2_valid <= 1'b1;
      s2_vec   <= lane_y;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef ACT_STATS_EN
  localparam int NW = $clog2(VEC_SIZE + 1);

  logic [NW-1:0]        lane_neg_n, lane_clip_n, s2_neg_n, s2_clip_n;
  logic [CNT_WIDTH:0]   neg_sum, clip_sum;

  always_comb begin
    lane_neg_n  = '0;
    lane_clip_n = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      lane_neg_n  = lane_neg_n  + NW'(lane_neg[i]);
      lane_clip_n = lane_clip_n + NW'(lane_clip[i]);
    end
  end

  // Lane flags travel with the beat so counts land exactly on its output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_neg_n  <= '0;
      s2_clip_n <= '0;
    end else if (adv2) begin
      s2_neg_n  <= lane_neg_n;
      s2_clip_n <= lane_clip_n;
    end
  end

  assign neg_sum  = {1'b0, neg_cnt}  + (CNT_WIDTH+1)'(s2_neg_n);
  assign clip_sum = {1'b0, clip_cnt} + (CNT_WIDTH+1)'(s2_clip_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt  <= '0;
      clip_cnt <= '0;
    end else if (stats_clr) begin
      neg_cnt  <= '0;
      clip_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      neg_cnt  <= neg_sum[CNT_WIDTH]  ? '1 : neg_sum[CNT_WIDTH-1:0];
      clip_cnt <= clip_sum[CNT_WIDTH] ? '1 : clip_sum[CNT_WIDTH-1:0];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{lane_neg, lane_clip};
`endif

endmodule

// File: tb/tb_act_stream.sv
// Directed, table-driven bench for act_stream; the statistics checks are
// compiled in when ACT_STATS_EN is defined.
module tb_act_stream;
  import act_pkg::*;

  localparam int VS = 4;
  localparam int DW = 16;
  localparam int NV = 13;

  typedef struct {
    act_mode_e   mode;
    logic [3:0]  shift;
    logic [15:0] clip_max;
    logic [15:0] din  [VS];
    logic [15:0] dexp [VS];
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [DW-1:0] in_vec  [VS];
  logic signed [DW-1:0] out_vec [VS];
  act_mode_e   mode;
  logic [3:0]  leak_shift;
  logic signed [DW-1:0] clip_max;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

`ifdef ACT_STATS_EN
  logic stats_clr;
  logic [31:0] neg_cnt, clip_cnt;
  logic [3:0]  s_neg_cnt, s_clip_cnt;
  logic s_in_ready, s_out_valid;
  logic signed [DW-1:0] s_out_vec [VS];

  act_stream #(.CNT_WIDTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_vec(in_vec), .mode(mode), .leak_shift(leak_shift), .clip_max(clip_max),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_vec(s_out_vec),
    .stats_clr(stats_clr), .neg_cnt(s_neg_cnt), .clip_cnt(s_clip_cnt)
  );
`endif

  act_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .mode(mode), .leak_shift(leak_shift), .clip_max(clip_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec)
`ifdef ACT_STATS_EN
    , .stats_clr(stats_clr), .neg_cnt(neg_cnt), .clip_cnt(clip_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input string name, input vec_t v);
    checkOutput({name, " out_valid"}, {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < VS; i++)
      checkOutput($sformatf("%s lane%0d", name, i), {16'h0, out_vec[i]}, {16'h0, v.dexp[i]});
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid   = 1'b1;
    mode       = v.mode;
    leak_shift = v.shift;
    clip_max   = v.clip_max;
    for (int i = 0; i < VS; i++) in_vec[i] = v.din[i];
  endtask

  task automatic setVec(input int idx, input act_mode_e m, input logic [3:0] sh,
                        input logic [15:0] cm, input logic [63:0] din, input logic [63:0] dexp);
    vecs[idx].mode     = m;
    vecs[idx].shift    = sh;
    vecs[idx].clip_max = cm;
    for (int i = 0; i < VS; i++) begin
      vecs[idx].din[i]  = din[63-16*i -: 16];
      vecs[idx].dexp[i] = dexp[63-16*i -: 16];
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int src, k;
    logic acc;

    setVec(0,  ACT_RELU,   4'd0,  16'h0000, {16'hFF00,16'h0180,16'h0000,16'h7FFF}, {16'h0000,16'h0180,16'h0000,16'h7FFF});
    setVec(1,  ACT_LEAKY,  4'd3,  16'h0000, {16'hFF00,16'hFFFF,16'h0040,16'h8000}, {16'hFFE0,16'hFFFF,16'h0040,16'hF000});
    setVec(2,  ACT_CLIP,   4'd0,  16'h0600, {16'h0700,16'h05FF,16'hFF00,16'h0600}, {16'h0600,16'h05FF,16'h0000,16'h0600});
    setVec(3,  ACT_CLIP,   4'd0,  16'hFF00, {16'h0700,16'h05FF,16'hFF00,16'h0600}, {16'h0000,16'h0000,16'h0000,16'h0000});
    setVec(4,  ACT_BYPASS, 4'd0,  16'h0000, {16'h8000,16'hFFFF,16'h1234,16'h7FFF}, {16'h8000,16'hFFFF,16'h1234,16'h7FFF});
    setVec(5,  ACT_LEAKY,  4'd0,  16'h0000, {16'hFF00,16'h8001,16'h0005,16'hFFFF}, {16'hFF00,16'h8001,16'h0005,16'hFFFF});
    setVec(6,  ACT_RELU,   4'd0,  16'h0000, {16'h8000,16'h0001,16'hFFFF,16'h7FFE}, {16'h0000,16'h0001,16'h0000,16'h7FFE});
    setVec(7,  ACT_LEAKY,  4'd15, 16'h0000, {16'h8000,16'hFFFE,16'h7FFF,16'hC000}, {16'hFFFF,16'hFFFF,16'h7FFF,16'hFFFF});
    setVec(8,  ACT_BYPASS, 4'd0,  16'h0000, {16'h1111,16'h2222,16'h3333,16'h4444}, {16'h1111,16'h2222,16'h3333,16'h4444});
    setVec(9,  ACT_RELU,   4'd0,  16'h0000, {16'hAAAA,16'h5555,16'h0001,16'hFFFF}, {16'h0000,16'h5555,16'h0001,16'h0000});
    setVec(10, ACT_LEAKY,  4'd1,  16'h0000, {16'hFFF0,16'h0010,16'h8000,16'hFFFF}, {16'hFFF8,16'h0010,16'hC000,16'hFFFF});
    setVec(11, ACT_CLIP,   4'd0,  16'h0100, {16'h0200,16'h0080,16'h8000,16'h7FFF}, {16'h0100,16'h0080,16'h0000,16'h0100});
    setVec(12, ACT_BYPASS, 4'd0,  16'h0000, {16'hFFFF,16'h8000,16'hFF00,16'hFFFE}, {16'hFFFF,16'h8000,16'hFF00,16'hFFFE});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = ACT_RELU; leak_shift = '0; clip_max = '0;
    for (int i = 0; i < VS; i++) in_vec[i] = '0;
`ifdef ACT_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset in_ready", {31'h0, in_ready}, 32'h1);
    for (int i = 0; i < VS; i++)
      checkOutput($sformatf("reset out_vec lane%0d", i), {16'h0, out_vec[i]}, 32'h0);
    rst_n = 1'b1;

    // Isolated beats: nothing at one cycle, the result at exactly two.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk); applyStimulus(vecs[v]);
      @(negedge clk); in_valid = 1'b0;
      checkOutput($sformatf("vec%0d latency early", v), {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      checkVec($sformatf("vec%0d", v), vecs[v]);
    end

    // Back-to-back mixed-mode stream at one beat per cycle.
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c < 8) applyStimulus(vecs[c]);
      else       in_valid = 1'b0;
      #1;
      if (c >= 2 && c <= 9) checkVec($sformatf("stream%0d", c - 2), vecs[c - 2]);
      if (c == 10) checkOutput("stream drained", {31'h0, out_valid}, 32'h0);
    end

    // Backpressure: two beats fill the pipe, then hold until released.
    @(negedge clk); out_ready = 1'b0; applyStimulus(vecs[8]); #1;
    checkOutput("bp in_ready A", {31'h0, in_ready}, 32'h1);
    @(negedge clk); applyStimulus(vecs[9]); #1;
    checkOutput("bp in_ready B", {31'h0, in_ready}, 32'h1);
    checkOutput("bp no output yet", {31'h0, out_valid}, 32'h0);
    @(negedge clk); applyStimulus(vecs[10]); #1;
    checkOutput("bp full in_ready", {31'h0, in_ready}, 32'h0);
    checkVec("bp hold A", vecs[8]);
    @(negedge clk); #1;
    checkOutput("bp still full", {31'h0, in_ready}, 32'h0);
    checkVec("bp hold A again", vecs[8]);
    out_ready = 1'b1; #1;
    src = 10; k = 0;
    while (k < 4) begin
      checkVec($sformatf("bp order %0d", k), vecs[8 + k]);
      k++;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) begin
        src++;
        if (src < 12) applyStimulus(vecs[src]);
        else          in_valid = 1'b0;
      end
      #1;
    end
    checkOutput("bp drained", {31'h0, out_valid}, 32'h0);

    // Reset with two beats in flight drops both.
    @(negedge clk); out_ready = 1'b0; applyStimulus(vecs[8]);
    @(negedge clk); applyStimulus(vecs[9]);
    @(negedge clk); in_valid = 1'b0; #1;
    checkOutput("rst pre out_valid", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0; #1;
    checkOutput("rst async out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst async in_ready", {31'h0, in_ready}, 32'h1);
    for (int i = 0; i < VS; i++)
      checkOutput($sformatf("rst async lane%0d", i), {16'h0, out_vec[i]}, 32'h0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("rst no stale %0d", c), {31'h0, out_valid}, 32'h0);
    end

`ifdef ACT_STATS_EN
    checkOutput("stats reset neg", neg_cnt, 32'h0);
    checkOutput("stats reset clip", clip_cnt, 32'h0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); applyStimulus(vecs[2]);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stats clip neg", neg_cnt, 32'd3);
    checkOutput("stats clip clip", clip_cnt, 32'd3);
    checkOutput("stats small neg", {28'h0, s_neg_cnt}, 32'd3);

    @(negedge clk); applyStimulus(vecs[2]);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checkOutput("stats clr with transfer valid", {31'h0, out_valid}, 32'h1);
    stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0; #1;
    checkOutput("stats cleared neg", neg_cnt, 32'h0);
    checkOutput("stats cleared clip", clip_cnt, 32'h0);

    for (int b = 0; b < 5; b++) begin
      @(negedge clk); applyStimulus(vecs[12]);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("stats neg 20", neg_cnt, 32'd20);
    checkOutput("stats saturate neg", {28'h0, s_neg_cnt}, 32'hF);
    checkOutput("stats bypass no clip", {28'h0, s_clip_cnt}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
